// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake into the UART transmitter queue.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frames go out LSB first with optional
// parity and one or two stop bits, back-to-back while words remain queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               s,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q;
  logic [BW-1:0]        baud_cnt_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q, txd_q, busy_q, done_q;
  logic                 push, pop, bit_end, last_stop;
  logic [DATA_BITS-1:0] head;

  assign s.s_ready  = !rst && (count_q < CW'(FIFO_DEPTH));
  assign push       = s.s_valid && s.s_ready;
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_cnt_q == BW'(BAUD_DIV - 1));
  assign last_stop  = (state_q == S_STOP) && bit_end && (bit_idx_q == 4'(STOP_BITS - 1));
  // A word written this edge is not counted yet, so it can only be popped one edge later.
  assign pop        = (count_q != '0) && ((state_q == S_IDLE) || last_stop);

  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q    <= S_START;
            shift_q    <= head;
            parity_q   <= (^head) ^ (PARITY == 1);
            baud_cnt_q <= '0;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                txd_q   <= parity_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q   <= S_STOP;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
          end
        end
        S_STOP: begin
          // Registered pulse lands exactly on the last cycle of the final stop bit.
          if ((bit_idx_q == 4'(STOP_BITS - 1)) && (baud_cnt_q == BW'(BAUD_DIV - 2)))
            done_q <= 1'b1;
          if (bit_end) begin
            if (bit_idx_q != 4'(STOP_BITS - 1)) begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end else if (pop) begin
              state_q  <= S_START;
              shift_q  <= head;
              parity_q <= (^head) ^ (PARITY == 1);
              txd_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
